// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes I/S/B/U/J immediates at push time and
// delivers them in order through a 2-entry valid/ready output buffer.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     Instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_data,
    output logic [2:0]      imm_fmt,
    output logic [31:0]     out_instr,
    output logic            illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [1:0] Full = DEPTH[1:0];

    localparam logic [2:0] FmtNone = 3'd0;
    localparam logic [2:0] FmtI    = 3'd1;
    localparam logic [2:0] FmtS    = 3'd2;
    localparam logic [2:0] FmtB    = 3'd3;
    localparam logic [2:0] FmtU    = 3'd4;
    localparam logic [2:0] FmtJ    = 3'd5;

    logic [1:0]      count_q, count_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            in_ready_q, in_ready_d;

    logic [XLEN-1:0] imm_q   [2];
    logic [2:0]      fmt_q   [2];
    logic [31:0]     instr_q [2];
    logic            ill_q   [2];

    logic            push, pop;
    logic            s;
    logic [63:0]     imm64;
    logic [2:0]      fmt_new;
    logic            ill_new;

    // Decode full 64-bit sign extension, then truncate to XLEN
    always_comb begin
        s       = Instruction[31];
        imm64   = '0;
        fmt_new = FmtNone;
        ill_new = 1'b0;
        unique case (Instruction[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: begin
                imm64   = {{52{s}}, Instruction[31:20]};
                fmt_new = FmtI;
            end
            7'b0100011: begin
                imm64   = {{52{s}}, Instruction[31:25], Instruction[11:7]};
                fmt_new = FmtS;
            end
            7'b1100011: begin
                imm64   = {{51{s}}, Instruction[31], Instruction[7], Instruction[30:25],
                           Instruction[11:8], 1'b0};
                fmt_new = FmtB;
            end
            7'b0110111, 7'b0010111: begin
                imm64   = {{32{s}}, Instruction[31:12], 12'b0};
                fmt_new = FmtU;
            end
            7'b1101111: begin
                imm64   = {{43{s}}, Instruction[31], Instruction[19:12], Instruction[20],
                           Instruction[30:21], 1'b0};
                fmt_new = FmtJ;
            end
            default: begin
                ill_new = 1'b1;
            end
        endcase
    end

    assign in_ready  = in_ready_q & ~reset;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        in_ready_d = (count_d < Full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            in_ready_q <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                imm_q[i]   <= '0;
                fmt_q[i]   <= '0;
                instr_q[i] <= '0;
                ill_q[i]   <= 1'b0;
            end
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            in_ready_q <= in_ready_d;
            if (push) begin
                imm_q[wr_ptr_q]   <= imm64[XLEN-1:0];
                fmt_q[wr_ptr_q]   <= fmt_new;
                instr_q[wr_ptr_q] <= Instruction;
                ill_q[wr_ptr_q]   <= ill_new;
            end
        end
    end

    // Idle outputs read as zero so an empty buffer never shows a stale entry
    assign imm_data  = out_valid ? imm_q[rd_ptr_q]   : '0;
    assign imm_fmt   = out_valid ? fmt_q[rd_ptr_q]   : '0;
    assign out_instr = out_valid ? instr_q[rd_ptr_q] : '0;
    assign illegal   = out_valid ? ill_q[rd_ptr_q]   : 1'b0;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined RISC-V immediate generator. Covers all base immediate formats: I, S, B, U and J.
- Decodes the format from the opcode and sign-extends the immediate to XLEN.
- Flags unsupported opcodes.
- Results pass through a 2-entry output buffer with valid/ready handshakes on both sides.
- Sits between instruction fetch/decode and the ALU-operand/branch-target logic of the datapath.

Parameters:
XLEN, 64, output immediate width; legal values 32 and 64 only.
DEPTH, 2, output buffer entries; fixed at 2, and the count register is 2 bits wide.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  Instruction is valid this cycle.
in_ready  output  1  Block can accept an instruction this cycle.
Instruction  input  32  Raw instruction word.
out_valid  output  1  Head entry is valid.
out_ready  input  1  Consumer accepts the head entry.
imm_data  output  XLEN  Sign-extended immediate of the head entry.
imm_fmt  output  3  Head format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
out_instr  output  32  Instruction word of the head entry, passed through.
illegal  output  1  Head opcode is not one of the supported opcodes.

Behaviour:
- Reset (synchronous, active-high):
  - count=0, read pointer=0, write pointer=0.
  - out_valid=0, in_ready=0 during the reset cycle, then 1.
  - imm_data=0, imm_fmt=0, out_instr=0, illegal=0.
  - Reset mid-operation discards all buffered entries. Any push or pop in the reset cycle is ignored.
- Handshakes:
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready = (count < 2), registered. It never depends combinationally on out_ready.
  - out_valid = (count != 0).
  - Outputs are driven from the head entry. They stay stable while out_valid && !out_ready.
- Latency: an instruction pushed in cycle N is visible at the output in cycle N+1 if the buffer was empty. It waits behind older entries otherwise. Order is strictly FIFO.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count unchanged. The head advances and the new entry is written to the tail.
  - When full (count=2), in_ready=0, so no push occurs. A pop in that cycle sets in_ready=1 for the next cycle.
- Pointers are 1 bit each and wrap 1 to 0.
- Format decode is combinational, on Instruction[6:0] at push time; the result is stored in the entry. Let s = Instruction[31].
  - I-type, opcodes 0000011, 0010011, 0011011, 1100111, 1110011: {s repeated XLEN-12, Instruction[31:20]}.
  - S-type, 0100011: {s repeated XLEN-12, Instruction[31:25], Instruction[11:7]}.
  - B-type, 1100011: {s repeated XLEN-13, Instruction[31], Instruction[7], Instruction[30:25], Instruction[11:8], 0}.
  - U-type, 0110111 and 0010111: {s repeated XLEN-32, Instruction[31:12], 12 zeros}.
  - J-type, 1101111: {s repeated XLEN-21, Instruction[31], Instruction[19:12], Instruction[20], Instruction[30:21], 0}.
  - Any other opcode: imm_data=0, imm_fmt=0, illegal=1. The entry is still buffered and delivered in order.
- Width rules: with XLEN=32, U-type has no extension bits and every result is truncated to 32 bits.
- in_valid=0: no push, and Instruction is don't-care.

Test Plan:
1. Reset, XLEN=64.
   - Push 0xFFF00093 (addi x1,x0,-1), out_ready=1.
   - Next cycle: out_valid=1, imm_data=0xFFFFFFFFFFFFFFFF, imm_fmt=1, illegal=0.
2. Back-to-back push of 0x00512423 (sw), 0xFE000EE3 (beq -4), 0x123450B7 (lui), 0x0080006F (jal +8), with out_ready=1.
   - Outputs in order, one per cycle, starting 1 cycle after the first push.
   - imm_data: 8, 0xFFFFFFFFFFFFFFFC, 0x0000000012345000, 8.
   - imm_fmt: 2, 3, 4, 5.
3. out_ready=0, push 3 instructions on consecutive cycles.
   - First two accepted; in_ready=0 in the cycle after the second push; the third is held.
   - Head output is stable.
   - Raise out_ready: entries drain in order and the third is accepted.
4. Push 0x00000000.
   - imm_data=0, imm_fmt=0, illegal=1.
   - A following legal instruction has illegal=0.
5. count=1, simultaneous push and pop for 4 cycles.
   - count stays 1, in_ready stays 1.
   - Each output appears exactly 1 cycle after its push.
   - Pointer wrap is exercised.
6. Buffer full, assert reset for 1 cycle.
   - Next cycle: out_valid=0, in_ready=1, imm_data=0.
   - A push in the reset cycle is not stored.
   - Repeat test 2 with XLEN=32: beq gives 0xFFFFFFFC and lui gives 0x12345000.
